alu_share_arbiter: RTL

Shares one combinational 16-bit ALU between two requesters (e.g. EX-stage and address-gen/branch unit) using valid/ready handshakes. Round-robin arbitration grants one operation at a time. The block registers operands into the ALU and the ALU result back out, then returns result and zero flag to the granted requester. Sits between the requesters and the ALU instance; it owns alu_a, alu_b and alu_control.

---
 rtl/alu_share_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lends one combinational ALU to two valid/ready requesters.
// Operands and results are registered, so each operation takes three cycles: IDLE, EXEC, RESP.
module alu_share_arbiter #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OPW       = 4,
  parameter bit          INIT_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state;
  logic   prio;
  logic   owner;

  logic             grant_valid;
  logic             grant_id;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             owner_rsp_ready;

  // prio only breaks ties; a lone requester is always granted.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (grant_id) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
  end

  assign req0_ready      = (state == StIdle) && grant_valid && !grant_id;
  assign req1_ready      = (state == StIdle) && grant_valid && grant_id;
  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;
  assign busy            = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      prio        <= INIT_PRIO;
      owner       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (grant_valid) begin
            alu_control <= sel_op;
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            owner       <= grant_id;
            state       <= StExec;
          end
        end
        StExec: begin
          if (owner) begin
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
            rsp1_valid  <= 1'b1;
          end else begin
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
            rsp0_valid  <= 1'b1;
          end
          state <= StResp;
        end
        StResp: begin
          // Result registers keep their value after completion; only valid drops.
          if (owner_rsp_ready) begin
            if (owner) begin
              rsp1_valid <= 1'b0;
            end else begin
              rsp0_valid <= 1'b0;
            end
            prio  <= ~owner;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
